// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding, AES round-count constants and round index width
package aes_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} aes_state_e;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam int ROUND_IDX_W = 4;
endpackage

// File: rtl/aes_round_counter.sv
// aes_round_counter: round index register; clr zeroes it, inc with en advances it by one
module aes_round_counter
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   inc,
  input  logic                   en,
  output logic [ROUND_IDX_W-1:0] count
);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else if (en && inc) count <= count + 1'b1;
endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: AES round sequencer (IDLE/LOAD/ROUND/FINAL/DONE) with registered datapath strobes, stall, abort and pass led
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   result_ok,
  output logic                   busy,
  output logic                   done,
  output logic                   dp_load,
  output logic                   dp_round_en,
  output logic                   dp_final,
  output logic                   key_step,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   led
);
  localparam logic [ROUND_IDX_W-1:0] LAST = ROUND_IDX_W'(NR - 1);
  aes_state_e state_q, state_d;
  logic in_round_d;
  always_comb begin
    state_d = (state_q == IDLE)  ? (start ? LOAD : IDLE)
            : (state_q == DONE)  ? IDLE
            : abort              ? IDLE
            : (state_q == LOAD)  ? ROUND
            : (state_q == ROUND) ? ((round_idx == LAST) ? FINAL : ROUND)
            : DONE;
    in_round_d = (state_d == ROUND) || (state_d == FINAL);
  end
  aes_round_counter u_cnt (
    .clk  (clk),
    .clr  (reset || (enable && (state_d == IDLE || state_d == LOAD))),
    .inc  (in_round_d),
    .en   (enable),
    .count(round_idx)
  );
  // strobes are registered from the next state so they align with the state register;
  // a stalled cycle clears them while busy keeps its value
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      dp_load     <= 1'b0;
      dp_round_en <= 1'b0;
      dp_final    <= 1'b0;
      key_step    <= 1'b0;
      led         <= 1'b0;
    end else if (enable) begin
      state_q     <= state_d;
      busy        <= state_d != IDLE;
      done        <= state_d == DONE;
      dp_load     <= state_d == LOAD;
      dp_round_en <= in_round_d;
      dp_final    <= state_d == FINAL;
      key_step    <= in_round_d;
      if (state_q == DONE) led <= result_ok;
    end else begin
      done        <= 1'b0;
      dp_load     <= 1'b0;
      dp_round_en <= 1'b0;
      dp_final    <= 1'b0;
      key_step    <= 1'b0;
    end
endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: directed scenarios and random stimulus against a step-count reference model for NR=10 and NR=14
module tb_aes_round_sched;
  import aes_pkg::*;
  logic clk = 1'b0;
  logic reset, enable, start, abort, result_ok;
  logic busy[2], done[2], load[2], re[2], fin[2], ks[2], led[2];
  logic [3:0] idx[2];
  int n_vec = 0, n_err = 0;
  int nr[2] = '{10, 14};
  int pos[2];
  logic led_m[2], enl[2];
  int cyc, re_cnt[2], ks_cnt[2], done_cnt[2], done_cyc[2];
  always #5 clk = ~clk;
  aes_round_sched #(.NR(NR_128)) dut10 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort), .result_ok(result_ok),
    .busy(busy[0]), .done(done[0]), .dp_load(load[0]), .dp_round_en(re[0]), .dp_final(fin[0]),
    .key_step(ks[0]), .round_idx(idx[0]), .led(led[0])
  );
  aes_round_sched #(.NR(NR_256)) dut14 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort), .result_ok(result_ok),
    .busy(busy[1]), .done(done[1]), .dp_load(load[1]), .dp_round_en(re[1]), .dp_final(fin[1]),
    .key_step(ks[1]), .round_idx(idx[1]), .led(led[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] obs(input int j);
    return {busy[j], done[j], load[j], re[j], fin[j], ks[j], led[j], idx[j]};
  endfunction
  // pos: -1 idle, 0 load, 1..NR rounds (NR is the final one), NR+1 done
  function automatic logic [10:0] exp_vec(input int j);
    int p = pos[j];
    int n = nr[j];
    logic a = enl[j];
    logic [3:0] ix = (p <= 0) ? 4'd0 : (p <= n) ? 4'(p) : 4'(n);
    logic rnd = (p >= 1) && (p <= n);
    return {p >= 0, a && p == n + 1, a && p == 0, a && rnd, a && p == n, a && rnd, led_m[j], ix};
  endfunction
  task automatic step();
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        pos[j] = -1;
        led_m[j] = 1'b0;
        enl[j] = 1'b0;
      end else begin
        enl[j] = enable;
        if (enable) begin
          if (pos[j] == -1) pos[j] = start ? 0 : -1;
          else if (pos[j] == nr[j] + 1) begin
            led_m[j] = result_ok;
            pos[j] = -1;
          end else if (abort) pos[j] = -1;
          else pos[j]++;
        end
      end
    end
    @(negedge clk);
    cyc++;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("nr%0d_cyc%0d", nr[j], cyc), {21'b0, obs(j)}, {21'b0, exp_vec(j)});
      if (re[j]) re_cnt[j]++;
      if (ks[j]) ks_cnt[j]++;
      if (done[j]) begin
        done_cnt[j]++;
        if (done_cyc[j] < 0) done_cyc[j] = cyc;
      end
    end
  endtask
  task automatic begin_scn();
    cyc = 0;
    for (int j = 0; j < 2; j++) begin
      re_cnt[j] = 0;
      ks_cnt[j] = 0;
      done_cnt[j] = 0;
      done_cyc[j] = -1;
    end
  endtask
  task automatic wait_idx(input logic [3:0] v);
    int k = 0;
    while (idx[0] !== v && k < 40) begin
      step();
      k++;
    end
    check("wait_idx", {28'b0, idx[0]}, {28'b0, v});
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0; result_ok = 1'b0;
    begin_scn();
    repeat (2) step();
    check("reset_out10", {21'b0, obs(0)}, 32'd0);
    check("reset_out14", {21'b0, obs(1)}, 32'd0);
    reset = 1'b0; enable = 1'b1; result_ok = 1'b1;
    step();
    // nominal block, result_ok=1
    begin_scn();
    pulse_start();
    repeat (19) step();
    check("lat10", done_cyc[0], 12);
    check("lat14", done_cyc[1], 16);
    check("re_cnt10", re_cnt[0], 10);
    check("ks_cnt14", ks_cnt[1], 14);
    check("led10", {31'b0, led[0]}, 32'd1);
    // stall of three cycles at round 5
    begin_scn();
    pulse_start();
    wait_idx(4'd5);
    enable = 1'b0;
    repeat (3) begin
      step();
      check("stall_idx", {28'b0, idx[0]}, 32'd5);
      check("stall_re", {31'b0, re[0]}, 32'd0);
    end
    enable = 1'b1;
    repeat (20) step();
    check("stall_lat10", done_cyc[0], 15);
    check("stall_lat14", done_cyc[1], 19);
    check("stall_re10", re_cnt[0], 10);
    check("stall_re14", re_cnt[1], 14);
    // abort at round 4, then a fresh block with result_ok=0
    result_ok = 1'b0;
    begin_scn();
    pulse_start();
    wait_idx(4'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy10", {31'b0, busy[0]}, 32'd0);
    check("abort_busy14", {31'b0, busy[1]}, 32'd0);
    repeat (20) step();
    check("abort_done", done_cnt[0] + done_cnt[1], 0);
    check("abort_led", {30'b0, led[0], led[1]}, 32'd3);
    begin_scn();
    pulse_start();
    repeat (19) step();
    check("after_abort_done10", done_cnt[0], 1);
    check("nr14_lat", done_cyc[1], 16);
    check("nr14_ks", ks_cnt[1], 14);
    check("nr14_led", {31'b0, led[1]}, 32'd0);
    // reset mid-operation at round 7
    result_ok = 1'b1;
    begin_scn();
    pulse_start();
    wait_idx(4'd7);
    reset = 1'b1;
    step();
    check("midreset10", {21'b0, obs(0)}, 32'd0);
    check("midreset14", {21'b0, obs(1)}, 32'd0);
    reset = 1'b0;
    step();
    // start with enable=0 and start while busy are both ignored
    begin_scn();
    enable = 1'b0;
    start = 1'b1;
    repeat (3) step();
    check("dis_start_busy", {31'b0, busy[0]}, 32'd0);
    enable = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    pulse_start();
    repeat (25) step();
    check("one_done10", done_cnt[0], 1);
    check("one_done14", done_cnt[1], 1);
    // random traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      result_ok = 1'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES rounds; legal values are 10, 12 and 14.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: global advance enable; 0 freezes the block.
REQ-005 SHALL have port start, input, 1 bit: request to process one block.
REQ-006 SHALL have port abort, input, 1 bit: cancels the operation in progress.
REQ-007 SHALL have port result_ok, input, 1 bit: the datapath's output-matches-expected flag, valid in DONE.
REQ-008 SHALL have port busy, output, 1 bit: high from LOAD through DONE inclusive.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port dp_load, output, 1 bit: datapath loads plaintext and performs the initial AddRoundKey.
REQ-011 SHALL have port dp_round_en, output, 1 bit: datapath performs one round this cycle.
REQ-012 SHALL have port dp_final, output, 1 bit: current round omits MixColumns.
REQ-013 SHALL have port key_step, output, 1 bit: key schedule advances one round key.
REQ-014 SHALL have port round_idx, output, 4 bits: current round number, 0..NR.
REQ-015 SHALL have port led, output, 1 bit: pass indicator for the last completed block.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL and DONE.
REQ-017 IDLE: when enable=1 and start=1, SHALL go to LOAD; otherwise SHALL stay in IDLE.
REQ-018 LOAD: SHALL drive dp_load=1 and round_idx=0, then go to ROUND with round_idx=1.
REQ-019 ROUND: SHALL drive dp_round_en=1 and key_step=1, and increment round_idx each enabled cycle; when round_idx=NR-1, SHALL go to FINAL.
REQ-020 FINAL: SHALL drive dp_round_en=1, dp_final=1, key_step=1 and round_idx=NR, then go to DONE.
REQ-021 DONE: SHALL drive done=1 for exactly one cycle, register led<=result_ok, and go to IDLE.
REQ-022 Latency: with enable held at 1, done SHALL rise on the (NR+2)th edge after the edge that samples start (12 for NR=10).
REQ-023 The block SHALL assert dp_round_en for exactly NR cycles and key_step for exactly NR cycles per block.
REQ-024 enable=0 SHALL hold the state and round_idx, and SHALL force dp_load, dp_round_en, dp_final, key_step and done to 0; busy SHALL be unaffected.
REQ-025 Any stall SHALL resume in the same state, so the round count per block is unchanged.
REQ-026 start SHALL be ignored while busy=1 or enable=0; there is no queuing.
REQ-027 abort=1 with enable=1 in LOAD, ROUND or FINAL SHALL go to IDLE on the next edge, with no done pulse and led unchanged.
REQ-028 abort in IDLE or DONE SHALL have no effect; in DONE, completion SHALL win.
REQ-029 start and abort asserted together in IDLE SHALL be treated as start.
REQ-030 All strobes SHALL be decoded from registered state only; no input-to-output combinational path is permitted.

Reset
REQ-031 reset=1 SHALL, on the next edge, set the state to IDLE and round_idx=0.
REQ-032 The following outputs SHALL be 0 after reset: busy, done, dp_load, dp_round_en, dp_final, key_step and led.
REQ-033 reset SHALL take priority over enable, start and abort, including mid-operation.

Structure
REQ-034 Shared package aes_pkg SHALL hold the state enum, the NR_128/NR_192/NR_256 constants (10/12/14) and ROUND_IDX_W=4.
REQ-035 round_idx SHALL be implemented in one sub-module, aes_round_counter, with inputs clr/inc/en and count output; everything else SHALL be inline.

Verification
REQ-036 Scenario: NR=10, enable=1, start pulsed at cycle 0, result_ok=1 → dp_load at cycle 1; dp_round_en at cycles 2–11; dp_final at cycle 11 only; done at cycle 12; led=1.
REQ-037 Scenario: enable dropped for 3 cycles while round_idx=5 → strobes are 0 and round_idx holds 5; done is delayed by exactly 3 cycles; dp_round_en count is still 10.
REQ-038 Scenario: abort at round_idx=4 → IDLE next cycle; no done; led keeps its prior value; a new start then completes normally.
REQ-039 Scenario: reset asserted at round_idx=7 → all outputs are 0 and IDLE on the next edge; led cleared.
REQ-040 Scenario: start re-pulsed while busy, and start with enable=0 → both ignored; exactly one done occurs.
REQ-041 Scenario: NR=14 with result_ok=0 → 14 key_step pulses; round_idx=14 in FINAL; done at cycle 16; led=0.
